// File: rtl/fsub_seq_ctrl.sv
// Sequential subtractor: A + ~B + BI evaluated two bits per cycle through a
// single borrow-chain slice, with START/ABORT handshake and a one-cycle DONE.
module fsub_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             BOUT
);

    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_nx;
    logic             chain_q;
    logic [1:0]       slice_s;
    logic             slice_mid;
    logic             slice_c;
    logic             accept;
    logic             last_slice;
    logic             step;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Two-bit borrow-chain slice on the low pair of the shifting operands.
    always_comb begin
        slice_s[0] = a_q[0] ^ ~b_q[0] ^ chain_q;
        slice_mid  = maj3(a_q[0], ~b_q[0], chain_q);
        slice_s[1] = a_q[1] ^ ~b_q[1] ^ slice_mid;
        slice_c    = maj3(a_q[1], ~b_q[1], slice_mid);
    end

    // Partial result fills from the top so the final pair lands in the LSB-correct place.
    assign part_nx = WIDTH'({slice_s, part_q} >> 2);

    assign accept     = (state != ST_RUN) && START && !ABORT;
    assign last_slice = (cnt == LAST_SLICE);
    assign step       = (state == ST_RUN) && !ABORT;

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (ABORT)
                    state_nx = ST_IDLE;
                else if (last_slice)
                    state_nx = ST_FIN;
                else
                    state_nx = ST_RUN;
            end
            default: begin
                state_nx = accept ? ST_RUN : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            chain_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            part_q  <= '0;
            chain_q <= BI;
            cnt     <= '0;
        end else if (step) begin
            a_q     <= a_q >> 2;
            b_q     <= b_q >> 2;
            part_q  <= part_nx;
            chain_q <= slice_c;
            cnt     <= last_slice ? '0 : cnt + CW'(1);
        end
    end

    // Visible result only moves on the RUN->FIN edge.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            S    <= '0;
            BOUT <= 1'b0;
        end else if (step && last_slice) begin
            S    <= part_nx;
            BOUT <= slice_c;
        end
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_fsub_seq_ctrl.sv
// Bench for fsub_seq_ctrl: cycle-level reference model plus directed vectors.
module tb_fsub_seq_ctrl;

    localparam int W = 16;

    logic         CK    = 1'b0;
    logic         RSTN  = 1'b1;
    logic         START = 1'b0;
    logic         ABORT = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         BI    = 1'b1;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         BOUT;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fsub_seq_ctrl #(.WIDTH(W)) dut (
        .CK   (CK),
        .RSTN (RSTN),
        .START(START),
        .ABORT(ABORT),
        .A    (A),
        .B    (B),
        .BI   (BI),
        .BUSY (BUSY),
        .DONE (DONE),
        .S    (S),
        .BOUT (BOUT)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus the arithmetic result.
    int           m_left;
    bit           m_done;
    logic [W-1:0] m_s, p_s;
    logic         m_bout, p_b;

    always @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_bout <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (ABORT) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        m_s    <= p_s;
                        m_bout <= p_b;
                    end
                end
            end else if (START && !ABORT) begin
                m_left     <= W / 2;
                {p_b, p_s} <= {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, BI};
            end
        end
    end

    always @(negedge CK) begin
        if (RSTN && chk_en) begin
            chk("busy", 32'(BUSY), 32'(m_left != 0));
            chk("done", 32'(DONE), 32'(m_done));
            chk("s",    32'(S),    32'(m_s));
            chk("bout", 32'(BOUT), 32'(m_bout));
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        @(negedge CK);
        A = a; B = b; BI = bi; START = 1'b1;
        @(negedge CK);
        START = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!DONE && n < 40) begin
            @(negedge CK);
            n++;
        end
        if (!DONE) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE expected DONE within 40 cycles");
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] s;
        logic         bout;
    } vec_t;

    vec_t vecs[7] = '{
        '{16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1},
        '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0},
        '{16'h0005, 16'h0005, 1'b0, 16'hFFFF, 1'b0},
        '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1},
        '{16'h00FF, 16'hFF00, 1'b0, 16'h01FE, 1'b0},
        '{16'hAAAA, 16'h5555, 1'b1, 16'h5555, 1'b1}
    };

    initial begin
        int  n;
        bit  seen_done;

        #1 RSTN = 1'b0;
        #11;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_s",    32'(S),    32'd0);
        chk("rst_bout", 32'(BOUT), 32'd0);
        @(negedge CK);
        RSTN   = 1'b1;
        chk_en = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bi);
            chk("vec_busy", 32'(BUSY), 32'd1);
            wait_done(n);
            chk("vec_latency", 32'(n), 32'd8);
            chk("vec_s",    32'(S),    32'(vecs[i].s));
            chk("vec_bout", 32'(BOUT), 32'(vecs[i].bout));
        end

        // Abort in the fourth RUN cycle after a good result.
        start_op(16'h1234, 16'h0234, 1'b1);
        wait_done(n);
        chk("pre_abort_s", 32'(S), 32'h1000);
        start_op(16'hFFFF, 16'h0001, 1'b1);
        repeat (3) @(negedge CK);
        ABORT = 1'b1;
        @(negedge CK);
        ABORT = 1'b0;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_s",    32'(S),    32'h1000);
        chk("abort_bout", 32'(BOUT), 32'd1);
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge CK);
            if (DONE) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        // ABORT beats START in IDLE.
        @(negedge CK);
        A = 16'h0F0F; B = 16'h0101; START = 1'b1; ABORT = 1'b1;
        @(negedge CK);
        START = 1'b0; ABORT = 1'b0;
        chk("abort_start_busy", 32'(BUSY), 32'd0);

        // START pulses during RUN are ignored.
        start_op(16'h0003, 16'h0001, 1'b1);
        repeat (2) begin
            @(negedge CK);
            A = 16'hFFFF; B = 16'h1234; BI = 1'b0; START = 1'b1;
            @(negedge CK);
            START = 1'b0;
        end
        wait_done(n);
        chk("ignore_latency", 32'(4 + n), 32'd8);
        chk("ignore_s",    32'(S),    32'h0002);
        chk("ignore_bout", 32'(BOUT), 32'd1);

        // Back-to-back: START accepted in FIN.
        A = 16'h0010; B = 16'h0020; BI = 1'b0; START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        chk("b2b_busy", 32'(BUSY), 32'd1);
        wait_done(n);
        chk("b2b_gap",  32'(1 + n), 32'd9);
        chk("b2b_s",    32'(S),    32'hFFEF);
        chk("b2b_bout", 32'(BOUT), 32'd0);

        // Asynchronous reset mid-RUN, then an immediate START.
        start_op(16'h0005, 16'h0004, 1'b1);
        repeat (2) @(negedge CK);
        @(posedge CK);
        #2 RSTN = 1'b0;
        #1;
        chk("async_busy", 32'(BUSY), 32'd0);
        chk("async_done", 32'(DONE), 32'd0);
        chk("async_s",    32'(S),    32'd0);
        chk("async_bout", 32'(BOUT), 32'd0);
        @(negedge CK);
        RSTN = 1'b1;
        A = 16'h1234; B = 16'h0234; BI = 1'b1; START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        chk("post_rst_busy", 32'(BUSY), 32'd1);
        wait_done(n);
        chk("post_rst_latency", 32'(n), 32'd8);
        chk("post_rst_s",    32'(S),    32'h1000);
        chk("post_rst_bout", 32'(BOUT), 32'd1);

        repeat (3) @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
